// File: rtl/operand_fetch_regfile.sv
// Register file with a one-entry operand latch feeding the function unit, plus a per-register
// pending scoreboard. Optional write-back forwarding is enabled by defining RF_BYPASS_EN.
module operand_fetch_regfile #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3,
  parameter int FS_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  input  logic [FS_W-1:0]   FSin,
  input  logic [ADDR_W-1:0] DA,
  input  logic              LD,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] Adata,
  output logic [DATA_W-1:0] Bdata,
  output logic [FS_W-1:0]   FS,
  output logic [ADDR_W-1:0] DAout,
  output logic              LDout,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t             state_r, state_s;
  logic [DATA_W-1:0]      rf_r [NREG];
  logic [NREG-1:0]        pend_r, pend_s;
  logic [DATA_W-1:0]      adata_r, bdata_r, a_val_s, b_val_s;
  logic [FS_W-1:0]        fs_r;
  logic [ADDR_W-1:0]      daout_r;
  logic                   ldout_r;
  logic                   a_byp_s, b_byp_s, hazard_s, inready_s, accept_s;

  // Operand selection, hazard detection and handshake
  always_comb begin
    a_byp_s = 1'b0;
    b_byp_s = 1'b0;
`ifdef RF_BYPASS_EN
    a_byp_s = WrEn && (WrAddr == AA);
    b_byp_s = WrEn && (WrAddr == BA);
`endif
    if (a_byp_s) a_val_s = WrData;
    else         a_val_s = rf_r[AA];
    if (b_byp_s) b_val_s = WrData;
    else         b_val_s = rf_r[BA];
    hazard_s  = (pend_r[AA] && !a_byp_s) || (pend_r[BA] && !b_byp_s);
    inready_s = !hazard_s && ((state_r == EMPTY) || OutReady);
    accept_s  = InValid && inready_s;
  end

  // Output buffer next state and scoreboard update (a set on accept beats a same-edge clear)
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_s = FULL;
        else          state_s = EMPTY;
      end
      FULL: begin
        if (accept_s)      state_s = FULL;
        else if (OutReady) state_s = EMPTY;
        else               state_s = FULL;
      end
      default: state_s = EMPTY;
    endcase
    if (WrEn) pend_s[WrAddr] = 1'b0;
    else      pend_s = pend_s;
    if (accept_s && LD) pend_s[DA] = 1'b1;
    else                pend_s = pend_s;
  end

  // State, register array, scoreboard and operand latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
      pend_r  <= {NREG{1'b0}};
      adata_r <= {DATA_W{1'b0}};
      bdata_r <= {DATA_W{1'b0}};
      fs_r    <= {FS_W{1'b0}};
      daout_r <= {ADDR_W{1'b0}};
      ldout_r <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_r[i] <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
      if (WrEn) rf_r[WrAddr] <= WrData;
      if (accept_s) begin
        adata_r <= a_val_s;
        bdata_r <= b_val_s;
        fs_r    <= FSin;
        daout_r <= DA;
        ldout_r <= LD;
      end
    end
  end

  assign InReady  = inready_s;
  assign OutValid = (state_r == FULL);
  assign Adata    = adata_r;
  assign Bdata    = bdata_r;
  assign FS       = fs_r;
  assign DAout    = daout_r;
  assign LDout    = ldout_r;

endmodule
